// File: rtl/md5_ctrl_pkg.sv
// Shared command codes, state encodings and default printable range for the
// MD5 brute-force match controller.
package md5_ctrl_pkg;

  localparam logic [31:0] CMD_RESET_GEN     = 32'h5230_0000;
  localparam logic [31:0] CMD_START         = 32'h5230_0001;
  localparam logic [31:0] CMD_SET_EXP       = 32'h5230_1000;
  localparam logic [31:0] CMD_SET_EXP_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] CMD_SET_RANGE     = 32'h5230_2000;
  localparam logic [31:0] CMD_COUNT_LO      = 32'h5230_3000;
  localparam logic [31:0] CMD_COUNT_HI      = 32'h5230_3001;
  localparam logic [31:0] CMD_GET_TEXT      = 32'h5230_4000;
  localparam logic [31:0] CMD_GET_TEXT_MASK = 32'hFFFF_FF00;
  localparam logic [31:0] CMD_STATUS        = 32'h5230_5000;
  localparam logic [31:0] CMD_HIT_COUNT     = 32'h5230_5001;

  localparam logic [7:0] RANGE_MIN_DEFAULT = 8'h61;
  localparam logic [7:0] RANGE_MAX_DEFAULT = 8'h7a;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_RUN  = 2'd1,
    RS_HIT  = 2'd2
  } run_state_e;

  typedef enum logic {
    DS_WAIT = 1'b0,
    DS_ARG  = 1'b1
  } dec_state_e;

  typedef enum logic [2:0] {
    RD_CNT_LO = 3'd0,
    RD_CNT_HI = 3'd1,
    RD_TEXT   = 3'd2,
    RD_STATUS = 3'd3,
    RD_HITS   = 3'd4
  } rd_sel_e;

endpackage

// File: rtl/md5_text_delay.sv
// PIPE_DEPTH-deep {valid, text} shift register that keeps candidate text aligned
// with the MD5 core latency; shifts only while en is high, clr drops all valids.
module md5_text_delay #(
  parameter int PIPE_DEPTH = 64,
  parameter int TEXT_W     = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [TEXT_W-1:0] in_text,
  output logic              out_valid,
  output logic [TEXT_W-1:0] out_text
);

  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [TEXT_W-1:0]     text_q [PIPE_DEPTH];
  logic [TEXT_W-1:0]     text_d [PIPE_DEPTH];

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < PIPE_DEPTH; i++) text_d[i] = text_q[i];
    if (en) begin
      valid_d[0] = in_valid;
      text_d[0]  = in_text;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        text_d[i]  = text_q[i-1];
      end
    end
    if (clr) valid_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Text payload carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PIPE_DEPTH; i++) text_q[i] <= text_d[i];
  end

  assign out_valid = valid_q[PIPE_DEPTH-1];
  assign out_text  = text_q[PIPE_DEPTH-1];

endmodule

// File: rtl/md5_match_controller.sv
// Brute-force MD5 match controller: candidate/digest alignment, target compare,
// run FSM and host command decoder. Optional feature macro: MD5_MULTI_HIT_EN.
module md5_match_controller
  import md5_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH  = 64,
  parameter int TEXT_W      = 128,
  parameter int NUM_TARGETS = 4,
  parameter int COUNT_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [31:0]       cmd_data,
  input  logic              cand_valid,
  input  logic [TEXT_W-1:0] cand_text,
  input  logic [31:0]       dig_a,
  input  logic [31:0]       dig_b,
  input  logic [31:0]       dig_c,
  input  logic [31:0]       dig_d,
  output logic              gen_reset,
  output logic              gen_run,
  output logic [7:0]        range_min,
  output logic [7:0]        range_max,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              matched,
  output logic [3:0]        match_index,
  output logic [TEXT_W-1:0] match_text
);

  localparam int TEXT_WORDS = TEXT_W / 32;

  run_state_e           run_q, run_d;
  dec_state_e           dec_q, dec_d;
  logic                 pend_range_q, pend_range_d;
  logic [7:0]           pend_tgt_q, pend_tgt_d;
  logic [1:0]           pend_word_q, pend_word_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [31:0]          tgt_q [NUM_TARGETS][4];
  logic [31:0]          tgt_d [NUM_TARGETS][4];
  logic [NUM_TARGETS-1:0] tgt_valid_q, tgt_valid_d;
  logic [7:0]           range_min_q, range_min_d, range_max_q, range_max_d;
  logic                 matched_q, matched_d;
  logic [3:0]           match_index_q, match_index_d;
  logic [TEXT_W-1:0]    match_text_q, match_text_d;
  logic                 rd_valid_q, rd_valid_d;
  rd_sel_e              rd_sel_q, rd_sel_d;
  logic [7:0]           rd_nn_q, rd_nn_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
`ifdef MD5_MULTI_HIT_EN
  logic [15:0]          hit_count_q, hit_count_d;
`endif

  logic                 tail_valid;
  logic [TEXT_W-1:0]    tail_text;
  logic                 hit;
  logic [3:0]           hit_idx;
  logic                 cmd_wait, cmd_reset_gen, cmd_start;

  assign cmd_wait      = cmd_valid && (dec_q == DS_WAIT);
  assign cmd_reset_gen = cmd_wait && (cmd_data == CMD_RESET_GEN);
  assign cmd_start     = cmd_wait && (cmd_data == CMD_START);

  md5_text_delay #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .TEXT_W     (TEXT_W)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .en        (run_q == RS_RUN),
    .clr       (cmd_reset_gen),
    .in_valid  (cand_valid),
    .in_text   (cand_text),
    .out_valid (tail_valid),
    .out_text  (tail_text)
  );

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 4'd0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (tail_valid && tgt_valid_q[i] &&
          tgt_q[i][0] == dig_a && tgt_q[i][1] == dig_b &&
          tgt_q[i][2] == dig_c && tgt_q[i][3] == dig_d) begin
        hit     = (run_q == RS_RUN);
        hit_idx = 4'(i);
      end
    end
  end

  always_comb begin
    run_d         = run_q;
    dec_d         = dec_q;
    pend_range_d  = pend_range_q;
    pend_tgt_d    = pend_tgt_q;
    pend_word_d   = pend_word_q;
    count_d       = count_q;
    for (int i = 0; i < NUM_TARGETS; i++)
      for (int w = 0; w < 4; w++) tgt_d[i][w] = tgt_q[i][w];
    tgt_valid_d   = tgt_valid_q;
    range_min_d   = range_min_q;
    range_max_d   = range_max_q;
    matched_d     = matched_q;
    match_index_d = match_index_q;
    match_text_d  = match_text_q;
    rd_valid_d    = 1'b0;
    rd_sel_d      = rd_sel_q;
    rd_nn_d       = rd_nn_q;
    rsp_valid_d   = rd_valid_q;
    rsp_data_d    = rsp_data_q;
`ifdef MD5_MULTI_HIT_EN
    hit_count_d   = hit_count_q;
`endif

    if (cmd_valid && dec_q == DS_ARG) begin
      dec_d = DS_WAIT;
      if (pend_range_q) begin
        if (cmd_data[7:0] <= cmd_data[15:8]) begin
          range_min_d = cmd_data[7:0];
          range_max_d = cmd_data[15:8];
        end
      end else begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (pend_tgt_q == 8'(i)) begin
            tgt_d[i][pend_word_q] = cmd_data;
            tgt_valid_d[i]        = (pend_word_q == 2'd3);
          end
        end
      end
    end else if (cmd_wait) begin
      if ((cmd_data & CMD_SET_EXP_MASK) == CMD_SET_EXP) begin
        dec_d        = DS_ARG;
        pend_range_d = 1'b0;
        pend_tgt_d   = cmd_data[11:4];
        pend_word_d  = cmd_data[1:0];
      end else if (cmd_data == CMD_SET_RANGE) begin
        dec_d        = DS_ARG;
        pend_range_d = 1'b1;
      end else if (cmd_data == CMD_COUNT_LO) begin
        rd_valid_d = 1'b1;
        rd_sel_d   = RD_CNT_LO;
      end else if (cmd_data == CMD_COUNT_HI) begin
        rd_valid_d = 1'b1;
        rd_sel_d   = RD_CNT_HI;
      end else if ((cmd_data & CMD_GET_TEXT_MASK) == CMD_GET_TEXT) begin
        rd_valid_d = 1'b1;
        rd_sel_d   = RD_TEXT;
        rd_nn_d    = cmd_data[7:0];
      end else if (cmd_data == CMD_STATUS) begin
        rd_valid_d = 1'b1;
        rd_sel_d   = RD_STATUS;
`ifdef MD5_MULTI_HIT_EN
      end else if (cmd_data == CMD_HIT_COUNT) begin
        rd_valid_d = 1'b1;
        rd_sel_d   = RD_HITS;
`endif
      end
    end

    case (run_q)
      RS_IDLE: if (cmd_start && !matched_q) run_d = RS_RUN;
`ifndef MD5_MULTI_HIT_EN
      RS_RUN:  if (hit) run_d = RS_HIT;
`endif
      RS_HIT:  run_d = RS_HIT;
      default: run_d = run_q;
    endcase

    if (run_q == RS_RUN && cand_valid) count_d = count_q + COUNT_W'(1);

    if (hit && !cmd_reset_gen) begin
      matched_d     = 1'b1;
      match_index_d = hit_idx;
      match_text_d  = tail_text;
`ifdef MD5_MULTI_HIT_EN
      if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
`endif
    end

    // ResetGen overrides any hit or count update in the same cycle.
    if (cmd_reset_gen) begin
      run_d     = RS_IDLE;
      count_d   = '0;
      matched_d = 1'b0;
`ifdef MD5_MULTI_HIT_EN
      hit_count_d = 16'd0;
`endif
    end

    if (rd_valid_q) begin
      case (rd_sel_q)
        RD_CNT_LO: rsp_data_d = count_q[31:0];
        RD_CNT_HI: rsp_data_d = 32'(count_q >> 32);
        RD_TEXT: begin
          rsp_data_d = '0;
          for (int i = 0; i < TEXT_WORDS; i++)
            if (rd_nn_q == 8'(i)) rsp_data_d = match_text_q[32*i +: 32];
        end
        RD_STATUS: rsp_data_d = {run_q, matched_q, match_index_q, 25'd0};
`ifdef MD5_MULTI_HIT_EN
        RD_HITS:   rsp_data_d = {16'd0, hit_count_q};
`endif
        default:   rsp_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q         <= RS_IDLE;
      dec_q         <= DS_WAIT;
      pend_range_q  <= 1'b0;
      pend_tgt_q    <= 8'd0;
      pend_word_q   <= 2'd0;
      count_q       <= '0;
      tgt_valid_q   <= '0;
      range_min_q   <= RANGE_MIN_DEFAULT;
      range_max_q   <= RANGE_MAX_DEFAULT;
      matched_q     <= 1'b0;
      match_index_q <= 4'd0;
      match_text_q  <= '0;
      rd_valid_q    <= 1'b0;
      rd_sel_q      <= RD_CNT_LO;
      rd_nn_q       <= 8'd0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'd0;
`ifdef MD5_MULTI_HIT_EN
      hit_count_q   <= 16'd0;
`endif
    end else begin
      run_q         <= run_d;
      dec_q         <= dec_d;
      pend_range_q  <= pend_range_d;
      pend_tgt_q    <= pend_tgt_d;
      pend_word_q   <= pend_word_d;
      count_q       <= count_d;
      tgt_valid_q   <= tgt_valid_d;
      range_min_q   <= range_min_d;
      range_max_q   <= range_max_d;
      matched_q     <= matched_d;
      match_index_q <= match_index_d;
      match_text_q  <= match_text_d;
      rd_valid_q    <= rd_valid_d;
      rd_sel_q      <= rd_sel_d;
      rd_nn_q       <= rd_nn_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
`ifdef MD5_MULTI_HIT_EN
      hit_count_q   <= hit_count_d;
`endif
    end
  end

  // Expected-hash words are qualified by tgt_valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TARGETS; i++)
      for (int w = 0; w < 4; w++) tgt_q[i][w] <= tgt_d[i][w];
  end

  assign gen_reset   = (run_q == RS_IDLE);
  assign gen_run     = (run_q == RS_RUN);
  assign range_min   = range_min_q;
  assign range_max   = range_max_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign matched     = matched_q;
  assign match_index = match_index_q;
  assign match_text  = match_text_q;

endmodule

// File: tb/tb_md5_match_controller.sv
// Directed bench for md5_match_controller: command-table reads plus hand-timed
// candidate/digest sequences. Honors MD5_MULTI_HIT_EN when defined.
module tb_md5_match_controller;

  localparam int PD = 64;

  localparam logic [31:0] C_RGEN   = 32'h5230_0000;
  localparam logic [31:0] C_START  = 32'h5230_0001;
  localparam logic [31:0] C_RANGE  = 32'h5230_2000;
  localparam logic [31:0] C_CLO    = 32'h5230_3000;
  localparam logic [31:0] C_CHI    = 32'h5230_3001;
  localparam logic [31:0] C_STATUS = 32'h5230_5000;
  localparam logic [31:0] C_HITS   = 32'h5230_5001;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic [31:0]  cmd_data;
  logic         cand_valid;
  logic [127:0] cand_text;
  logic [31:0]  dig_a, dig_b, dig_c, dig_d;
  logic         gen_reset, gen_run;
  logic [7:0]   range_min, range_max;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic         matched;
  logic [3:0]   match_index;
  logic [127:0] match_text;

  md5_match_controller dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cand_valid (cand_valid),
    .cand_text  (cand_text),
    .dig_a      (dig_a),
    .dig_b      (dig_b),
    .dig_c      (dig_c),
    .dig_d      (dig_d),
    .gen_reset  (gen_reset),
    .gen_run    (gen_run),
    .range_min  (range_min),
    .range_max  (range_max),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .matched    (matched),
    .match_index(match_index),
    .match_text (match_text)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic        rsp;
    logic [31:0] data;
  } vec_t;

  vec_t tab[$];
  int   checks = 0;
  int   errors = 0;
  logic multi;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] w);
    cmd_valid = 1'b1;
    cmd_data  = w;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 32'd0;
  endtask

  task automatic do_read(input string name, input logic [31:0] w, input logic [31:0] exp);
    send_cmd(w);
    tick();
    chk({name, ".vld"}, rsp_valid, 1'b1);
    chk(name, rsp_data, exp);
  endtask

  task automatic run_tab(input string tag);
    for (int i = 0; i < tab.size(); i++) begin
      send_cmd(tab[i].cmd);
      tick();
      chk($sformatf("%s[%0d].vld", tag, i), rsp_valid, tab[i].rsp);
      if (tab[i].rsp) chk($sformatf("%s[%0d].data", tag, i), rsp_data, tab[i].data);
    end
    tab.delete();
  endtask

  task automatic set_target(input int t, input logic [31:0] a, b, c, d);
    logic [31:0] base;
    base = 32'h5230_1000 | (32'(t) << 4);
    send_cmd(base | 32'd0); send_cmd(a);
    send_cmd(base | 32'd1); send_cmd(b);
    send_cmd(base | 32'd2); send_cmd(c);
    send_cmd(base | 32'd3); send_cmd(d);
  endtask

  // One valid candidate, then its digest exactly PD cycles later.
  task automatic cand_digest(input logic [127:0] txt, input logic [31:0] a, b, c, d,
                             input logic with_rgen);
    cand_valid = 1'b1;
    cand_text  = txt;
    tick();
    cand_valid = 1'b0;
    cand_text  = '0;
    repeat (PD - 1) tick();
    {dig_a, dig_b, dig_c, dig_d} = {a, b, c, d};
    if (with_rgen) begin
      cmd_valid = 1'b1;
      cmd_data  = C_RGEN;
    end
    tick();
    {dig_a, dig_b, dig_c, dig_d} = '0;
    cmd_valid = 1'b0;
    cmd_data  = 32'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
`ifdef MD5_MULTI_HIT_EN
    multi = 1'b1;
`else
    multi = 1'b0;
`endif
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0;
    cand_valid = 1'b0; cand_text = '0;
    {dig_a, dig_b, dig_c, dig_d} = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst.range_min", range_min, 8'h61);
    chk("rst.range_max", range_max, 8'h7a);
    chk("rst.gen_reset", gen_reset, 1'b1);
    chk("rst.gen_run", gen_run, 1'b0);
    chk("rst.matched", matched, 1'b0);
    chk("rst.match_index", match_index, 4'd0);
    chk("rst.match_text", match_text, 128'd0);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.rsp_data", rsp_data, 32'd0);

    tab.push_back('{C_STATUS, 1'b1, 32'h0000_0000});
    tab.push_back('{C_CLO, 1'b1, 32'd0});
    tab.push_back('{C_CHI, 1'b1, 32'd0});
    tab.push_back('{32'h5230_4000, 1'b1, 32'd0});
    tab.push_back('{32'h5230_4003, 1'b1, 32'd0});
    tab.push_back('{32'h5230_4004, 1'b1, 32'd0});
    tab.push_back('{32'h5230_6000, 1'b0, 32'd0});
    tab.push_back('{32'h1234_5678, 1'b0, 32'd0});
    tab.push_back('{C_HITS, multi, 32'd0});
    run_tab("reset_tab");

    // Out-of-range target: the argument (a Status code) must be swallowed.
    send_cmd(32'h5230_1053);
    send_cmd(C_STATUS);
    tick();
    chk("exp_oob.no_rsp", rsp_valid, 1'b0);
    do_read("exp_oob.status", C_STATUS, 32'h0000_0000);

    send_cmd(C_RANGE); send_cmd(32'h0000_2061);
    chk("range_rej.min", range_min, 8'h61);
    chk("range_rej.max", range_max, 8'h7a);
    send_cmd(C_RANGE); send_cmd(32'h0000_4141);
    chk("range_eq.min", range_min, 8'h41);
    chk("range_eq.max", range_max, 8'h41);
    send_cmd(C_RANGE); send_cmd(32'h0000_7a30);
    chk("range_ok.min", range_min, 8'h30);
    chk("range_ok.max", range_max, 8'h7a);

    // Single hit on target 2.
    set_target(2, 32'hd41d8cd9, 32'h8f00b204, 32'he9800998, 32'hecf8427e);
    send_cmd(C_START);
    chk("start.gen_run", gen_run, 1'b1);
    chk("start.gen_reset", gen_reset, 1'b0);
    cand_digest(128'h6162, 32'hd41d8cd9, 32'h8f00b204, 32'he9800998, 32'hecf8427e, 1'b0);
    chk("hit.matched", matched, 1'b1);
    chk("hit.index", match_index, 4'd2);
    chk("hit.text", match_text, 128'h6162);
    chk("hit.gen_run", gen_run, multi);
    tab.push_back('{32'h5230_4000, 1'b1, 32'h0000_6162});
    tab.push_back('{32'h5230_4001, 1'b1, 32'd0});
    tab.push_back('{32'h5230_4004, 1'b1, 32'd0});
    tab.push_back('{C_STATUS, 1'b1, multi ? 32'h6400_0000 : 32'hA400_0000});
    tab.push_back('{C_CLO, 1'b1, 32'd1});
    tab.push_back('{C_START, 1'b0, 32'd0});
    tab.push_back('{C_STATUS, 1'b1, multi ? 32'h6400_0000 : 32'hA400_0000});
    run_tab("hit_tab");
    cand_valid = 1'b1;
    repeat (3) tick();
    cand_valid = 1'b0;
    do_read("hit.count_frozen", C_CLO, multi ? 32'd4 : 32'd1);

    send_cmd(C_RGEN);
    chk("rgen.gen_reset", gen_reset, 1'b1);
    chk("rgen.gen_run", gen_run, 1'b0);
    chk("rgen.matched", matched, 1'b0);
    do_read("rgen.count", C_CLO, 32'd0);

    // 1000 non-matching candidates.
    send_cmd(C_START);
    for (int i = 0; i < 1000; i++) begin
      cand_valid = 1'b1;
      cand_text  = 128'(i);
      tick();
    end
    cand_valid = 1'b0;
    cand_text  = '0;
    repeat (PD + 2) tick();
    chk("run1000.matched", matched, 1'b0);
    do_read("run1000.lo", C_CLO, 32'd1000);
    do_read("run1000.hi", C_CHI, 32'd0);

    // Rewriting word a invalidates the target until word d is rewritten.
    send_cmd(C_RGEN);
    set_target(0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    send_cmd(32'h5230_1000); send_cmd(32'h11111111);
    send_cmd(C_START);
    cand_digest(128'h77, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0);
    chk("tgt_invalid.matched", matched, 1'b0);

    // Same digest in targets 1 and 3: lowest index wins.
    set_target(1, 32'haaaa0001, 32'hbbbb0002, 32'hcccc0003, 32'hdddd0004);
    set_target(3, 32'haaaa0001, 32'hbbbb0002, 32'hcccc0003, 32'hdddd0004);
    cand_digest(128'h1234, 32'haaaa0001, 32'hbbbb0002, 32'hcccc0003, 32'hdddd0004, 1'b0);
    chk("dual.matched", matched, 1'b1);
    chk("dual.index", match_index, 4'd1);
    chk("dual.text", match_text, 128'h1234);

    // ResetGen mid-run must flush the in-flight candidate.
    send_cmd(C_RGEN);
    send_cmd(C_START);
    cand_valid = 1'b1;
    cand_text  = 128'h1234;
    tick();
    cand_valid = 1'b0;
    cand_text  = '0;
    repeat (10) tick();
    send_cmd(C_RGEN);
    send_cmd(C_START);
    {dig_a, dig_b, dig_c, dig_d} = {32'haaaa0001, 32'hbbbb0002, 32'hcccc0003, 32'hdddd0004};
    repeat (PD + 4) tick();
    {dig_a, dig_b, dig_c, dig_d} = '0;
    chk("flush.matched", matched, 1'b0);
    chk("flush.gen_run", gen_run, 1'b1);
    do_read("flush.count", C_CLO, 32'd0);

    // Hit coinciding with ResetGen: ResetGen wins.
    cand_digest(128'h99, 32'haaaa0001, 32'hbbbb0002, 32'hcccc0003, 32'hdddd0004, 1'b1);
    chk("hit_rgen.matched", matched, 1'b0);
    chk("hit_rgen.gen_reset", gen_reset, 1'b1);

    if (multi) begin
      send_cmd(C_START);
      for (int k = 0; k < 3; k++)
        cand_digest(128'h500 + 128'(k), 32'haaaa0001, 32'hbbbb0002, 32'hcccc0003,
                    32'hdddd0004, 1'b0);
      chk("multi.gen_run", gen_run, 1'b1);
      chk("multi.text", match_text, 128'h502);
      do_read("multi.hits", C_HITS, 32'd3);
      do_read("multi.status", C_STATUS, 32'h6200_0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
